// File: rtl/mux_scan_nx1.sv
// Registered N-channel selector with a manual select mode and an auto-scan
// sequencer that dwells on each enabled channel and emits sample/sweep strobes.
module mux_scan_nx1 #(
    parameter int N_CH  = 4,
    parameter int WIDTH = 1,
    parameter int DWELL = 10,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      sel,
    input  logic [N_CH-1:0]       ch_mask,
    input  logic [N_CH*WIDTH-1:0] din,
    output logic [WIDTH-1:0]      z,
    output logic [SEL_W-1:0]      ch,
    output logic                  sample_valid,
    output logic                  scan_done,
    output logic                  sel_err
);

    localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MANUAL = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    state_t             state_q;
    state_t             next_state;
    logic [CNT_W-1:0]   cnt_q;
    logic               scan_live_q;
    logic               scan_entry;
    logic               dwell_end;
    logic               sel_ok;
    logic [SEL_W-1:0]   lowest_ch;
    logic [SEL_W-1:0]   next_ch;

    function automatic logic [WIDTH-1:0] pick(input logic [N_CH*WIDTH-1:0] d,
                                              input logic [SEL_W-1:0] idx);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (SEL_W'(i) == idx) r = d[i*WIDTH +: WIDTH];
        end
        return r;
    endfunction

    function automatic logic [SEL_W-1:0] lowest_set(input logic [N_CH-1:0] m);
        logic [SEL_W-1:0] r;
        r = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (m[i]) r = SEL_W'(i);
        end
        return r;
    endfunction

    // Descending scan with overwrite leaves the lowest enabled channel above cur;
    // if there is none, the wrap target (lowest enabled overall) survives.
    function automatic logic [SEL_W-1:0] next_set(input logic [N_CH-1:0] m,
                                                  input logic [SEL_W-1:0] cur);
        logic [SEL_W-1:0] r;
        r = lowest_set(m);
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (m[i] && (SEL_W'(i) > cur)) r = SEL_W'(i);
        end
        return r;
    endfunction

    always_comb begin
        next_state = ST_IDLE;
        if (en) next_state = mode ? ST_SCAN : ST_MANUAL;
        scan_entry = (state_q != ST_SCAN) || !scan_live_q;
        dwell_end  = (cnt_q == CNT_W'(DWELL - 1));
        sel_ok     = ({1'b0, sel} < (SEL_W + 1)'(N_CH));
        lowest_ch  = lowest_set(ch_mask);
        next_ch    = next_set(ch_mask, ch);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            scan_live_q  <= 1'b0;
            z            <= '0;
            ch           <= '0;
            sample_valid <= 1'b0;
            scan_done    <= 1'b0;
            sel_err      <= 1'b0;
        end else begin
            state_q      <= next_state;
            sample_valid <= 1'b0;
            scan_done    <= 1'b0;
            sel_err      <= 1'b0;
            case (next_state)
                ST_MANUAL: begin
                    cnt_q       <= '0;
                    scan_live_q <= 1'b0;
                    if (sel_ok) begin
                        ch           <= sel;
                        z            <= pick(din, sel);
                        sample_valid <= 1'b1;
                    end else begin
                        sel_err <= 1'b1;
                    end
                end
                ST_SCAN: begin
                    // An empty mask parks the sequencer; the next nonzero mask re-enters.
                    if (ch_mask == '0) begin
                        scan_live_q <= 1'b0;
                        if (state_q != ST_SCAN) cnt_q <= '0;
                    end else if (scan_entry) begin
                        ch          <= lowest_ch;
                        z           <= pick(din, lowest_ch);
                        cnt_q       <= '0;
                        scan_live_q <= 1'b1;
                    end else if (!dwell_end) begin
                        z     <= pick(din, ch);
                        cnt_q <= cnt_q + 1'b1;
                    end else begin
                        z            <= pick(din, ch);
                        ch           <= next_ch;
                        cnt_q        <= '0;
                        sample_valid <= 1'b1;
                        scan_done    <= (next_ch <= ch);
                    end
                end
                default: begin
                    cnt_q       <= '0;
                    scan_live_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/mux_scan_nx1.md
Name: mux_scan_nx1

Overview:
- Parametrised, registered N-channel, W-bit selector.
- Next generation of the team's combinational 4x1 mux.
- Two modes:
  - Manual: host-driven select, registered output.
  - Auto-scan: built-in sequencer visits the enabled channels round-robin, holds each for a programmable dwell, and emits sample and sweep-complete strobes.
- Feeds sampling and monitor logic that previously needed an external select counter.

Parameters:
- N_CH, 4, number of input channels (>=2).
- WIDTH, 1, bits per channel.
- DWELL, 10, cycles spent on each channel in auto-scan (>=1).
- SEL_W, $clog2(N_CH), select/channel index width (derived; not to be overridden).

Ports:
- clk  in  1  clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- en  in  1  block enable; 0 = idle/hold.
- mode  in  1  0 = manual, 1 = auto-scan.
- sel  in  SEL_W  channel select in manual mode.
- ch_mask  in  N_CH  auto-scan enable per channel; bit i = channel i.
- din  in  N_CH*WIDTH  channel data, flattened; channel i = din[i*WIDTH +: WIDTH].
- z  out  WIDTH  registered selected data.
- ch  out  SEL_W  index of channel currently selected.
- sample_valid  out  1  one-cycle strobe: z holds a committed sample.
- scan_done  out  1  one-cycle strobe: auto-scan sweep wrapped.
- sel_err  out  1  one-cycle strobe: manual sel >= N_CH.

Behaviour:
- One clock domain; reset is synchronous and active-high; no asynchronous paths.
- Reset, dominant over all inputs, including mid-dwell:
  - z=0, ch=0, dwell counter=0.
  - sample_valid=0, scan_done=0, sel_err=0.
  - state=IDLE.
- State is decoded from en/mode at every edge:
  - en=0 -> IDLE.
  - en=1, mode=0 -> MANUAL.
  - en=1, mode=1 -> SCAN.
  - Any state change clears the dwell counter.
- Strobes default to 0 every cycle unless set below.
- IDLE:
  - z, ch hold.
  - Counter held at 0.
  - No strobes.
- MANUAL, sel < N_CH:
  - ch <= sel, z <= din[sel].
  - Latency is 1 cycle from sel/din to z.
  - sample_valid=1 on every cycle spent in MANUAL.
- MANUAL, sel >= N_CH (only possible when N_CH is not a power of 2):
  - z, ch hold; sample_valid=0; sel_err=1 that cycle.
- SCAN entry (first edge in SCAN after IDLE/MANUAL/reset):
  - ch <= lowest set bit of ch_mask.
  - z <= din[that channel]; counter <= 0.
  - No strobes.
- SCAN steady state, counter < DWELL-1:
  - z <= din[ch], which tracks live data.
  - counter++; no strobes.
- SCAN steady state, counter == DWELL-1:
  - z <= din[ch]; sample_valid=1.
  - ch <= next set bit of ch_mask above ch, else lowest set bit (wrap).
  - counter <= 0.
  - scan_done=1 iff the wrap occurred, i.e. the new ch <= old ch.
- DWELL=1: advance on every edge; sample_valid is high every cycle.
- Single enabled channel: ch is constant; sample_valid and scan_done both fire every DWELL cycles.
- ch_mask=0 in SCAN (at entry or later):
  - z, ch, counter hold; no strobes.
  - When the mask becomes nonzero, the next edge behaves as SCAN entry.
- ch_mask changes mid-dwell with the current ch still enabled: the dwell completes; the new mask applies at the advance.
- Current ch masked off mid-dwell: the dwell still completes on that channel (no abort); the advance uses the new mask.
- mode toggles mid-dwell: the dwell is discarded, no strobe for the partial dwell, and the new mode applies on that edge.
- No combinational path from any input to any output.

Test Plan:
- Use N_CH=4, WIDTH=8, DWELL=4; din = {8'hD3, 8'hC2, 8'hB1, 8'hA0} for channels 3..0.
1. Reset: assert reset 2 cycles with en=1, mode=1 -> z=0, ch=0, all strobes 0; release -> next edge ch=0, z=8'hA0.
2. Manual sweep: en=1, mode=0, sel=0,1,2,3 on consecutive cycles -> z=A0,B1,C2,D3 each one cycle later; sample_valid high throughout; sel_err=0.
3. Auto-scan, full mask: ch_mask=4'b1111 ->
   - ch sequence 0,1,2,3,0 with 4 cycles each.
   - sample_valid on cycles 4, 8, 12, 16 after entry.
   - scan_done only on cycle 16.
   - z=A0/B1/C2/D3 during the matching dwells.
4. Sparse mask and wrap: ch_mask=4'b1010 ->
   - ch alternates 1,3,1.
   - scan_done at each 3->1 advance.
   - Clear the mask mid-dwell -> outputs hold, no strobes.
   - Set mask=4'b0100 -> ch=2 next edge, then sample_valid and scan_done together every 4 cycles.
5. Mid-operation events:
   - Toggle mode to 0 at counter=2 with sel=3 -> next edge z=D3, no scan strobe.
   - Assert reset at counter=1 in SCAN -> outputs return to reset values on that edge.
   - en=0 -> z and ch frozen for 5 cycles.
6. Live data: in SCAN on ch=2, change din ch2 to 8'h5A at counter=1 -> z=5A from the next edge; sample_valid at counter=3 with z=5A.
